memory: RTL and testbench

MEMORY -- requirements
Module: memory

---
 rtl/memory_pkg.sv | 85 ++++++++
 rtl/memory_memalign.sv | 25 ++
 rtl/memory.sv | 89 ++++++++
 tb/tb_memory.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_pkg.sv
// Shared bus types (common_pkg) and pipeline-stage types for the memory stage (pipes_pkg).
package common_pkg;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2,
        MSIZE8 = 2'd3
    } msize_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

endpackage

package pipes_pkg;
    import common_pkg::*;

    typedef struct packed {
        logic   regwrite;
        logic   memread;
        logic   memwrite;
        msize_t msize;
        logic   mem_unsigned;
        logic   csrwrite;
    } control_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instruction;
        logic [63:0] result;
        logic [63:0] memdata;
        logic [4:0]  dst;
        logic [11:0] csr_dst;
        logic [63:0] csrdata;
        control_t    ctl;
    } execute_data_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instruction;
        logic [63:0] result;
        logic [4:0]  dst;
        logic [11:0] csr_dst;
        logic [63:0] csrdata;
        control_t    ctl;
        logic        misalign;
    } memory_data_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    function automatic logic is_misaligned(input logic [2:0] offset, input msize_t size);
        case (size)
            MSIZE2:  return offset[0];
            MSIZE4:  return |offset[1:0];
            MSIZE8:  return |offset;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [7:0] size_mask(input msize_t size);
        case (size)
            MSIZE1:  return 8'h01;
            MSIZE2:  return 8'h03;
            MSIZE4:  return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/memory_memalign.sv
// Load-path alignment: picks the addressed bytes out of the 64-bit bus word and extends them.
module memalign
    import common_pkg::*;
(
    input  logic [63:0] raw,
    input  logic [2:0]  offset,
    input  msize_t      size,
    input  logic        is_unsigned,
    output logic [63:0] data
);

    logic [63:0] shifted;

    always_comb begin
        shifted = raw >> {offset, 3'b000};
        data    = '0;
        case (size)
            MSIZE1:  data = is_unsigned ? {56'b0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
            MSIZE2:  data = is_unsigned ? {48'b0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
            MSIZE4:  data = is_unsigned ? {32'b0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/memory.sv
// Memory pipeline stage: issues one data-bus access per load/store and stalls via data_ok until it completes.
module memory
    import common_pkg::*;
    import pipes_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  execute_data_t dataE,
    input  logic          valid_in,
    input  logic          advance,
    output dbus_req_t     dreq,
    input  dbus_resp_t    dresp,
    output logic          data_ok,
    output memory_data_t  dataM
);

    mem_state_t  state, state_next;
    logic        mem_op;
    logic        misalign;
    logic [63:0] load_data;
    logic [63:0] aligned_data;
    logic        unused_addr_ok;

    // Address handshake is not needed: the request is held until data_ok anyway.
    assign unused_addr_ok = dresp.addr_ok;

    assign mem_op   = valid_in && (dataE.ctl.memread || dataE.ctl.memwrite);
    assign misalign = mem_op && is_misaligned(dataE.result[2:0], dataE.ctl.msize);

    memalign u_memalign (
        .raw         (dresp.data),
        .offset      (dataE.result[2:0]),
        .size        (dataE.ctl.msize),
        .is_unsigned (dataE.ctl.mem_unsigned),
        .data        (aligned_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            load_data <= '0;
        end else begin
            state <= state_next;
            if (state == REQ && dresp.data_ok) begin
                load_data <= aligned_data;
            end
        end
    end

    always_comb begin
        state_next = state;
        data_ok    = 1'b0;
        case (state)
            IDLE: begin
                if (mem_op && !misalign) state_next = REQ;
                else                     data_ok    = 1'b1;
            end
            REQ: begin
                if (dresp.data_ok) state_next = DONE;
            end
            DONE: begin
                data_ok = 1'b1;
                if (advance) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        dreq.valid  = (state == REQ);
        dreq.addr   = dataE.result;
        dreq.size   = dataE.ctl.msize;
        dreq.strobe = dataE.ctl.memwrite ? (size_mask(dataE.ctl.msize) << dataE.result[2:0]) : 8'h00;
        dreq.data   = dataE.memdata << {dataE.result[2:0], 3'b000};
    end

    always_comb begin
        dataM.pc           = dataE.pc;
        dataM.instruction  = dataE.instruction;
        dataM.dst          = dataE.dst;
        dataM.csr_dst      = dataE.csr_dst;
        dataM.csrdata      = dataE.csrdata;
        dataM.ctl          = dataE.ctl;
        dataM.ctl.regwrite = dataE.ctl.regwrite && !misalign;
        dataM.misalign     = misalign;
        dataM.result       = (state == DONE && dataE.ctl.memread) ? load_data : dataE.result;
    end

endmodule

// File: tb/tb_memory.sv
// Bench for the memory stage: random loads/stores against a byte-array memory model with a result scoreboard.
module tb_memory;
    import common_pkg::*;
    import pipes_pkg::*;

    logic          clk = 1'b0;
    logic          reset;
    execute_data_t dataE;
    logic          valid_in;
    logic          advance;
    dbus_req_t     dreq;
    dbus_resp_t    dresp;
    logic          data_ok;
    memory_data_t  dataM;

    memory dut (
        .clk      (clk),
        .reset    (reset),
        .dataE    (dataE),
        .valid_in (valid_in),
        .advance  (advance),
        .dreq     (dreq),
        .dresp    (dresp),
        .data_ok  (data_ok),
        .dataM    (dataM)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [63:0] result;
        logic        misalign;
        logic        regwrite;
    } exp_t;

    typedef struct {
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } bus_exp_t;

    exp_t        exp_q[$];
    bus_exp_t    bus_q[$];
    logic [7:0]  ref_mem [0:16383];
    logic [7:0]  bus_mem [0:16383];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int          resp_delay  = -1;
    logic        resp_enable = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int idx(input logic [63:0] a);
        return int'(a & 64'h3FFF);
    endfunction

    // Little-endian read of nbytes from the reference memory, then extend.
    function automatic logic [63:0] model_load(input logic [63:0] addr, input int unsigned nbytes, input logic uns);
        logic [63:0] v = '0;
        for (int unsigned i = 0; i < nbytes; i++) v |= 64'(ref_mem[idx(addr + 64'(i))]) << (8 * i);
        if (!uns && v[8 * nbytes - 1])
            for (int unsigned i = 8 * nbytes; i < 64; i++) v[i] = 1'b1;
        return v;
    endfunction

    task automatic cmp_bus(input bus_exp_t b, input string tag);
        logic [63:0] m = '0;
        for (int unsigned j = 0; j < 8; j++) if (b.strobe[j]) m[8 * j +: 8] = 8'hFF;
        check({tag, "_addr"},   dreq.addr, b.addr);
        check({tag, "_size"},   64'(dreq.size), 64'(b.size));
        check({tag, "_strobe"}, 64'(dreq.strobe), 64'(b.strobe));
        check({tag, "_data"},   dreq.data & m, b.data);
    endtask

    // kind: 0 = ALU, 1 = load, 2 = store. Called just after a rising edge; returns just after one.
    task automatic issue(input int unsigned kind, input msize_t size, input logic uns,
                         input logic [63:0] addr, input logic [63:0] wdata,
                         input logic have_exp, input logic [63:0] exp_res, input int unsigned hold);
        int unsigned nbytes = 1 << size;
        int unsigned off    = int'(addr[2:0]);
        int unsigned waited = 0;
        logic        mis;
        exp_t        e;
        bus_exp_t    b;
        mis = (kind != 0) && ((addr % 64'(nbytes)) != 0);
        dataE.pc               = {$urandom, $urandom};
        dataE.instruction      = $urandom;
        dataE.result           = addr;
        dataE.memdata          = wdata;
        dataE.dst              = 5'($urandom);
        dataE.csr_dst          = 12'($urandom);
        dataE.csrdata          = {$urandom, $urandom};
        dataE.ctl.regwrite     = (kind != 2);
        dataE.ctl.memread      = (kind == 1);
        dataE.ctl.memwrite     = (kind == 2);
        dataE.ctl.msize        = size;
        dataE.ctl.mem_unsigned = uns;
        dataE.ctl.csrwrite     = 1'($urandom);
        e.pc       = dataE.pc;
        e.misalign = mis;
        e.regwrite = (kind != 2) && !mis;
        e.result   = addr;
        if (kind == 1 && !mis) e.result = have_exp ? exp_res : model_load(addr, nbytes, uns);
        if (kind != 0 && !mis) begin
            b.addr = addr; b.size = size; b.strobe = '0; b.data = '0;
            if (kind == 2)
                for (int unsigned i = 0; i < nbytes; i++) begin
                    b.strobe[off + i]       = 1'b1;
                    b.data[8 * (off + i) +: 8] = wdata[8 * i +: 8];
                    ref_mem[idx(addr + 64'(i))] = wdata[8 * i +: 8];
                end
            bus_q.push_back(b);
        end
        exp_q.push_back(e);
        valid_in = 1'b1;
        advance  = 1'b0;
        if (kind == 0) begin
            #1;
            check("alu_comb_data_ok", 64'(data_ok), 64'd1);
            check("alu_no_req", 64'(dreq.valid), 64'd0);
        end
        forever begin
            @(negedge clk); #1;
            if (data_ok) break;
            if (waited >= 20) begin
                check("wait_data_ok", 64'(data_ok), 64'd1);
                break;
            end
            waited++;
            // advance during an outstanding request must have no effect
            advance = dreq.valid ? 1'($urandom % 2) : 1'b0;
        end
        if (hold > 0) begin
            advance = 1'b0;
            for (int unsigned k = 0; k < hold; k++) begin
                @(negedge clk); #1;
                check("hold_data_ok", 64'(data_ok), 64'd1);
                check("hold_result", dataM.result, e.result);
                check("hold_no_req", 64'(dreq.valid), 64'd0);
            end
        end
        advance = 1'b1;
        @(posedge clk); #1;
        advance  = 1'b0;
        valid_in = 1'b0;
    endtask

    // Scoreboard monitor: an instruction retires on a cycle with valid_in, data_ok and advance.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk); #2;
            if (!reset && valid_in && advance && data_ok) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_retire: got result 0x%0h expected no retirement", dataM.result);
                end else begin
                    e = exp_q.pop_front();
                    check("result",   dataM.result, e.result);
                    check("misalign", 64'(dataM.misalign), 64'(e.misalign));
                    check("regwrite", 64'(dataM.ctl.regwrite), 64'(e.regwrite));
                    check("pc",       dataM.pc, e.pc);
                end
            end
        end
    end

    // Data-bus responder backed by its own byte memory.
    initial begin
        bus_exp_t    b;
        logic [63:0] base;
        logic [63:0] rd;
        int unsigned d;
        dresp = '0;
        forever begin
            @(negedge clk);
            if (resp_enable && !reset) begin
                if (dreq.valid) begin
                    if (bus_q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL unexpected_req: got addr 0x%0h expected no request", dreq.addr);
                        b.addr = dreq.addr; b.size = dreq.size; b.strobe = dreq.strobe; b.data = '0;
                    end else begin
                        b = bus_q.pop_front();
                        cmp_bus(b, "req");
                    end
                    d = (resp_delay >= 0) ? int'(resp_delay) : $urandom % 4;
                    for (int unsigned k = 0; k < d; k++) begin
                        @(negedge clk);
                        check("req_held_valid", 64'(dreq.valid), 64'd1);
                        cmp_bus(b, "held");
                    end
                    base = {dreq.addr[63:3], 3'b000};
                    rd   = '0;
                    for (int unsigned j = 0; j < 8; j++) begin
                        rd[8 * j +: 8] = bus_mem[idx(base + 64'(j))];
                        if (dreq.strobe[j]) bus_mem[idx(base + 64'(j))] = dreq.data[8 * j +: 8];
                    end
                    dresp.data    = rd;
                    dresp.data_ok = 1'b1;
                    @(posedge clk); #1;
                    dresp.data_ok = 1'b0;
                    dresp.data    = {$urandom, $urandom};
                    @(negedge clk);
                    check("req_dropped", 64'(dreq.valid), 64'd0);
                end else if ($urandom % 8 == 0) begin
                    dresp.data    = {$urandom, $urandom};
                    dresp.data_ok = 1'b1;
                    @(posedge clk); #1;
                    dresp.data_ok = 1'b0;
                end
            end
        end
    end

    initial begin
        int unsigned k, sz, nb;
        logic [63:0] a;
        for (int i = 0; i < 16384; i++) begin
            ref_mem[i] = 8'($urandom);
            bus_mem[i] = ref_mem[i];
        end
        reset    = 1'b1;
        valid_in = 1'b0;
        advance  = 1'b0;
        dataE    = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_dreq_valid", 64'(dreq.valid), 64'd0);
        check("reset_data_ok", 64'(data_ok), 64'd1);
        @(negedge clk);
        reset       = 1'b0;
        resp_enable = 1'b1;
        @(posedge clk); #1;

        issue(0, MSIZE8, 1'b0, 64'h1234, 64'h0, 1'b0, 64'h0, 0);

        for (int i = 0; i < 8; i++) begin
            ref_mem[16'h1000 + i] = (i == 3) ? 8'h80 : 8'h00;
            bus_mem[16'h1000 + i] = ref_mem[16'h1000 + i];
        end
        resp_delay = 1;
        issue(1, MSIZE1, 1'b0, 64'h1003, 64'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FF80, 3);
        issue(1, MSIZE1, 1'b1, 64'h1003, 64'h0, 1'b1, 64'h0000_0000_0000_0080, 0);
        resp_delay = 3;
        issue(2, MSIZE4, 1'b0, 64'h2004, 64'h0000_0000_DEAD_BEEF, 1'b0, 64'h0, 0);
        resp_delay = 0;
        issue(1, MSIZE4, 1'b1, 64'h2004, 64'h0, 1'b1, 64'h0000_0000_DEAD_BEEF, 0);
        issue(1, MSIZE4, 1'b0, 64'h2004, 64'h0, 1'b1, 64'hFFFF_FFFF_DEAD_BEEF, 0);
        resp_delay = -1;

        issue(1, MSIZE8, 1'b0, 64'h3004, 64'h0, 1'b0, 64'h0, 0);
        issue(1, MSIZE2, 1'b0, 64'h3001, 64'h0, 1'b0, 64'h0, 0);
        issue(2, MSIZE4, 1'b0, 64'h3002, 64'h55, 1'b0, 64'h0, 0);

        // Reset in the middle of a request, then a stale response after release.
        resp_enable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        dataE.result       = 64'h1008;
        dataE.ctl.memread  = 1'b1;
        dataE.ctl.memwrite = 1'b0;
        dataE.ctl.msize    = MSIZE4;
        valid_in = 1'b1;
        @(posedge clk); #1;
        check("rst_req_valid_before", 64'(dreq.valid), 64'd1);
        #2 reset = 1'b1;
        #1 check("rst_async_valid", 64'(dreq.valid), 64'd0);
        valid_in = 1'b0;
        #1 check("rst_data_ok", 64'(data_ok), 64'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        dresp.data    = {$urandom, $urandom};
        dresp.data_ok = 1'b1;
        @(posedge clk); #1;
        dresp.data_ok = 1'b0;
        check("stale_no_req", 64'(dreq.valid), 64'd0);
        check("stale_data_ok", 64'(data_ok), 64'd1);
        @(posedge clk); #1;
        check("stale_no_req_later", 64'(dreq.valid), 64'd0);
        resp_enable = 1'b1;
        issue(1, MSIZE4, 1'b0, 64'h1008, 64'h0, 1'b0, 64'h0, 0);

        for (int n = 0; n < 300; n++) begin
            k  = $urandom % 3;
            sz = $urandom % 4;
            nb = 1 << sz;
            a  = 64'h1000 + 64'($urandom % 256);
            if ($urandom % 5 != 0) a = a & ~64'(nb - 1);
            issue(k, msize_t'(sz), 1'($urandom), a, {$urandom, $urandom}, 1'b0, 64'h0,
                  ($urandom % 4 == 0) ? $urandom % 3 : 0);
            repeat ($urandom % 2) @(posedge clk);
            #1;
        end

        repeat (6) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        check("bus_queue_drained", 64'(bus_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
